// File: rtl/cpu_run_pkg.sv
// cpu_run_pkg: shared types and constants for the CPU run controller.
// Holds the controller state enum, the clkSel run-rate encodings and the
// PC / phase widths used by cpu_run_ctrl and run_tick_sel.
package cpu_run_pkg;

  localparam int PC_W    = 12;
  localparam int PHASE_W = 3;

  localparam logic [1:0] CLK_SEL_MANUAL = 2'b00;
  localparam logic [1:0] CLK_SEL_1HZ    = 2'b01;
  localparam logic [1:0] CLK_SEL_10HZ   = 2'b10;
  localparam logic [1:0] CLK_SEL_FREE   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_BRK  = 2'd3
  } run_state_e;

endpackage

// File: rtl/run_tick_sel.sv
// run_tick_sel: picks the tick source that paces RUN mode.
// Manual rate never ticks, the two slow rates pass their pulse through,
// and the free-running rate ticks on every clock.
module run_tick_sel
  import cpu_run_pkg::*;
(
  input  logic [1:0] clk_sel,
  input  logic       tick_1hz,
  input  logic       tick_10hz,
  output logic       tick
);

  // Combinational source mux so a rate change is seen on the very next sample
  always_comb begin
    tick = 1'b0;
    case (clk_sel)
      CLK_SEL_MANUAL: tick = 1'b0;
      CLK_SEL_1HZ:    tick = tick_1hz;
      CLK_SEL_10HZ:   tick = tick_10hz;
      CLK_SEL_FREE:   tick = 1'b1;
      default:        tick = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run / halt / single-step / breakpoint controller that issues
// one-clock CPU clock enables and tracks the phase within an instruction.
// Optional feature macro: RUN_CTRL_BP_EN enables the PC breakpoint and the
// BRK state; without it BRK is unreachable and bpHit stays low.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int CYCLES_PER_INSN = 8
)
(
  input  logic            clk,
  input  logic            nRst,
  input  logic [1:0]      clkSel,
  input  logic            tick1Hz,
  input  logic            tick10Hz,
  input  logic            stepReq,
  input  logic            runToggle,
  input  logic            stepInsn,
  input  logic            bpArm,
  input  logic [PC_W-1:0] bpAddr,
  input  logic [PC_W-1:0] pcAddr,
  output logic            cpuClkEn,
  output logic            running,
  output logic            bpHit,
  output logic [PHASE_W-1:0] cycPhase
);

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(CYCLES_PER_INSN - 1);

  run_state_e state_q, state_d;
  logic step_insn_q, step_insn_d;
  logic cpu_clk_en_q, cpu_clk_en_d;
  logic running_q, running_d;
  logic bp_hit_q, bp_hit_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic bypass_q, bypass_d;
  logic tick;
  logic bp_match;

  run_tick_sel u_tick_sel (
    .clk_sel   (clkSel),
    .tick_1hz  (tick1Hz),
    .tick_10hz (tick10Hz),
    .tick      (tick)
  );

`ifdef RUN_CTRL_BP_EN
  // A pending enable traps only at an instruction boundary on the armed PC,
  // unless this is the first enable after resuming from the breakpoint
  assign bp_match = bpArm && (phase_q == '0) && (pcAddr == bpAddr) && !bypass_q;
`else
  logic unused_bp_inputs;
  assign unused_bp_inputs = ^{bpArm, bpAddr, pcAddr};
  assign bp_match = 1'b0;
`endif

  // State register, including the step granularity latched on STEP entry
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= ST_IDLE;
      step_insn_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_insn_q <= step_insn_d;
    end
  end

  // Next-state logic; runToggle has priority over stepReq wherever both act
  always_comb begin
    state_d     = state_q;
    step_insn_d = step_insn_q;
    case (state_q)
      ST_IDLE: begin
        if (runToggle && (clkSel != CLK_SEL_MANUAL)) begin
          state_d = ST_RUN;
        end else if (stepReq) begin
          state_d     = ST_STEP;
          step_insn_d = stepInsn;
        end
      end
      ST_RUN: begin
        if (runToggle) begin
          state_d = ST_IDLE;
        end else if (tick && bp_match) begin
          state_d = ST_BRK;
        end
      end
      ST_STEP: begin
        if (!step_insn_q || (phase_q == LAST_PHASE)) begin
          state_d = ST_IDLE;
        end
      end
      ST_BRK: begin
        if (runToggle) begin
          state_d = ST_RUN;
        end else if (stepReq) begin
          state_d     = ST_STEP;
          step_insn_d = stepInsn;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: enables for the next clock plus state-decoded status flags
  always_comb begin
    cpu_clk_en_d = 1'b0;
    case (state_q)
      ST_RUN:  cpu_clk_en_d = tick && !runToggle && !bp_match;
      ST_STEP: cpu_clk_en_d = 1'b1;
      default: cpu_clk_en_d = 1'b0;
    endcase
    running_d = (state_d == ST_RUN);
`ifdef RUN_CTRL_BP_EN
    bp_hit_d  = (state_d == ST_BRK);
`else
    bp_hit_d  = 1'b0;
`endif
  end

  // Phase advances together with each issued enable; the bypass flag lives
  // from a breakpoint resume until the first enable is issued or RUN is left
  always_comb begin
    phase_d = phase_q;
    if (cpu_clk_en_d) begin
      phase_d = (phase_q == LAST_PHASE) ? '0 : phase_q + 1'b1;
    end
    bypass_d = bypass_q;
    if ((state_q == ST_BRK) && runToggle) begin
      bypass_d = 1'b1;
    end else if ((state_q != ST_RUN) || cpu_clk_en_d || runToggle) begin
      bypass_d = 1'b0;
    end
  end

  // Registered outputs and datapath flops
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      cpu_clk_en_q <= 1'b0;
      running_q    <= 1'b0;
      bp_hit_q     <= 1'b0;
      phase_q      <= '0;
      bypass_q     <= 1'b0;
    end else begin
      cpu_clk_en_q <= cpu_clk_en_d;
      running_q    <= running_d;
      bp_hit_q     <= bp_hit_d;
      phase_q      <= phase_d;
      bypass_q     <= bypass_d;
    end
  end

  assign cpuClkEn = cpu_clk_en_q;
  assign running  = running_q;
  assign bpHit    = bp_hit_q;
  assign cycPhase = phase_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed bench for cpu_run_ctrl with a cycle-level
// behavioural model compared against the DUT after every clock edge.
module tb_cpu_run_ctrl;

  localparam int CPI = 8;
`ifdef RUN_CTRL_BP_EN
  localparam bit BP_EN = 1'b1;
`else
  localparam bit BP_EN = 1'b0;
`endif

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STEP = 2;
  localparam int M_BRK  = 3;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic [1:0]  clkSel = 2'b00;
  logic        tick1Hz = 1'b0;
  logic        tick10Hz = 1'b0;
  logic        stepReq = 1'b0;
  logic        runToggle = 1'b0;
  logic        stepInsn = 1'b0;
  logic        bpArm = 1'b0;
  logic [11:0] bpAddr = 12'h000;
  logic [11:0] pcAddr = 12'h000;
  logic        cpuClkEn;
  logic        running;
  logic        bpHit;
  logic [2:0]  cycPhase;

  int checks = 0;
  int failures = 0;
  int enCount = 0;

  typedef struct packed {
    int   mode;
    int   left;
    int   phase;
    logic bypass;
    logic en;
  } model_t;

  model_t mdl = '0;

  cpu_run_ctrl #(.CYCLES_PER_INSN(CPI)) dut (
    .clk       (clk),
    .nRst      (nRst),
    .clkSel    (clkSel),
    .tick1Hz   (tick1Hz),
    .tick10Hz  (tick10Hz),
    .stepReq   (stepReq),
    .runToggle (runToggle),
    .stepInsn  (stepInsn),
    .bpArm     (bpArm),
    .bpAddr    (bpAddr),
    .pcAddr    (pcAddr),
    .cpuClkEn  (cpuClkEn),
    .running   (running),
    .bpHit     (bpHit),
    .cycPhase  (cycPhase)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  // One clock of controller behaviour in terms of the run/step/break rules
  function automatic model_t modelStep(input model_t m, input logic [1:0] sel,
                                       input logic rt, input logic sr, input logic si,
                                       input logic t1, input logic t10, input logic arm,
                                       input logic [11:0] addr, input logic [11:0] pc);
    model_t n = m;
    bit tick = (sel == 2'b11) || (sel == 2'b01 && t1) || (sel == 2'b10 && t10);
    n.en = 1'b0;
    case (m.mode)
      M_IDLE: begin
        if (rt && sel != 2'b00) n.mode = M_RUN;
        else if (sr) begin
          n.mode = M_STEP;
          n.left = si ? CPI - m.phase : 1;
        end
      end
      M_RUN: begin
        if (rt) begin
          n.mode = M_IDLE;
          n.bypass = 1'b0;
        end else if (tick) begin
          if (BP_EN && arm && m.phase == 0 && pc == addr && !m.bypass) n.mode = M_BRK;
          else begin
            n.en = 1'b1;
            n.bypass = 1'b0;
          end
        end
      end
      M_STEP: begin
        n.en = 1'b1;
        n.left = m.left - 1;
        if (n.left == 0) n.mode = M_IDLE;
      end
      default: begin
        if (rt) begin
          n.mode = M_RUN;
          n.bypass = 1'b1;
        end else if (sr) begin
          n.mode = M_STEP;
          n.left = si ? CPI - m.phase : 1;
        end
      end
    endcase
    if (n.en) n.phase = (m.phase + 1) % CPI;
    return n;
  endfunction

  // Model state follows the DUT clock and reset
  always @(posedge clk or negedge nRst) begin
    if (!nRst) mdl <= '0;
    else mdl <= modelStep(mdl, clkSel, runToggle, stepReq, stepInsn,
                          tick1Hz, tick10Hz, bpArm, bpAddr, pcAddr);
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison against the model, plus an enable pulse counter
  always @(posedge clk) begin
    #1;
    if (cpuClkEn) enCount++;
    checkOutput("cyc_cpuClkEn", int'(cpuClkEn), int'(mdl.en));
    checkOutput("cyc_running", int'(running), int'(mdl.mode == M_RUN));
    checkOutput("cyc_bpHit", int'(bpHit), int'(mdl.mode == M_BRK));
    checkOutput("cyc_cycPhase", int'(cycPhase), mdl.phase);
  end

  // Drive one clock of inputs from a falling edge; pulses drop afterwards
  task automatic applyStimulus(input logic [1:0] sel, input logic rt, input logic sr,
                               input logic si, input logic t1, input logic t10);
    clkSel    = sel;
    runToggle = rt;
    stepReq   = sr;
    stepInsn  = si;
    tick1Hz   = t1;
    tick10Hz  = t10;
    @(negedge clk);
    runToggle = 1'b0;
    stepReq   = 1'b0;
    stepInsn  = 1'b0;
    tick1Hz   = 1'b0;
    tick10Hz  = 1'b0;
  endtask

  task automatic idleCycles(input int n, input logic [1:0] sel);
    for (int i = 0; i < n; i++) applyStimulus(sel, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Bound on total run time
  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Directed scenarios
  initial begin
    repeat (3) @(negedge clk);
    checkOutput("rst_cpuClkEn", int'(cpuClkEn), 0);
    checkOutput("rst_running", int'(running), 0);
    checkOutput("rst_bpHit", int'(bpHit), 0);
    checkOutput("rst_cycPhase", int'(cycPhase), 0);
    nRst = 1'b1;
    @(negedge clk);

    $display("[TB] manual rate ignores runToggle in IDLE");
    applyStimulus(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("manual_rt_running", int'(running), 0);

    $display("[TB] free run at every clk");
    enCount = 0;
    applyStimulus(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("free_first_cycle_en", int'(cpuClkEn), 0);
    checkOutput("free_running", int'(running), 1);
    idleCycles(1, 2'b11);
    checkOutput("free_second_cycle_en", int'(cpuClkEn), 1);
    checkOutput("free_phase_first", int'(cycPhase), 1);
    idleCycles(15, 2'b11);
    applyStimulus(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("free_en_count", enCount, 16);
    checkOutput("free_phase_end", int'(cycPhase), 0);
    checkOutput("free_stop_running", int'(running), 0);

    $display("[TB] single-enable steps then instruction step from phase 3");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idleCycles(1, 2'b00);
    end
    checkOutput("step1_phase", int'(cycPhase), 3);
    enCount = 0;
    applyStimulus(2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idleCycles(5, 2'b00);
    checkOutput("stepinsn_en_count", enCount, 5);
    checkOutput("stepinsn_phase", int'(cycPhase), 0);
    checkOutput("stepinsn_running", int'(running), 0);

    $display("[TB] slow ticks and rate change");
    applyStimulus(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    enCount = 0;
    idleCycles(2, 2'b01);
    applyStimulus(2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("tick1_en", int'(cpuClkEn), 1);
    idleCycles(3, 2'b01);
    applyStimulus(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("tick10_at_1hz_en", int'(cpuClkEn), 0);
    applyStimulus(2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idleCycles(1, 2'b01);
    applyStimulus(2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idleCycles(2, 2'b01);
    applyStimulus(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("tick10_at_10hz_en", int'(cpuClkEn), 1);
    idleCycles(1, 2'b10);
    applyStimulus(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("stop_suppress_en", int'(cpuClkEn), 0);
    checkOutput("slow_en_count", enCount, 4);
    checkOutput("slow_phase", int'(cycPhase), 4);

    $display("[TB] breakpoint at 0x012");
    bpArm  = 1'b1;
    bpAddr = 12'h012;
    pcAddr = 12'h010;
    applyStimulus(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("bp_pre_phase", int'(cycPhase), 0);
    pcAddr = 12'h012;
    applyStimulus(2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef RUN_CTRL_BP_EN
    checkOutput("bp_hit", int'(bpHit), 1);
    checkOutput("bp_running", int'(running), 0);
    checkOutput("bp_no_en", int'(cpuClkEn), 0);
    applyStimulus(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_resume_running", int'(running), 1);
    checkOutput("bp_resume_hit", int'(bpHit), 0);
    applyStimulus(2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`else
    checkOutput("nobp_hit", int'(bpHit), 0);
`endif
    checkOutput("bp_pass_en", int'(cpuClkEn), 1);
    checkOutput("bp_pass_phase", int'(cycPhase), 1);
    for (int i = 0; i < 2; i++) applyStimulus(2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("bp_after_phase", int'(cycPhase), 3);
    applyStimulus(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_stop_running", int'(running), 0);
    bpArm = 1'b0;

    $display("[TB] reset in the middle of an instruction step");
    enCount = 0;
    applyStimulus(2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idleCycles(2, 2'b00);
    checkOutput("midstep_en_count", enCount, 2);
    checkOutput("midstep_en", int'(cpuClkEn), 1);
    nRst = 1'b0;
    #1;
    checkOutput("arst_cpuClkEn", int'(cpuClkEn), 0);
    checkOutput("arst_running", int'(running), 0);
    checkOutput("arst_bpHit", int'(bpHit), 0);
    checkOutput("arst_cycPhase", int'(cycPhase), 0);
    @(negedge clk);
    nRst = 1'b1;
    enCount = 0;
    idleCycles(5, 2'b00);
    checkOutput("post_rst_en_count", enCount, 0);
    checkOutput("post_rst_running", int'(running), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
